// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 4-bit ALU sequencing controller.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPark,
    StDrive,
    StCap,
    StDone
  } state_e;

  // Instruction field positions
  localparam int unsigned INSTR_W = 13;
  localparam int unsigned I_WIDE  = 12;
  localparam int unsigned S_MSB   = 11;
  localparam int unsigned S_LSB   = 8;
  localparam int unsigned I_M     = 7;
  localparam int unsigned I_CI    = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RA_MSB  = 3;
  localparam int unsigned RA_LSB  = 2;
  localparam int unsigned RB_MSB  = 1;
  localparam int unsigned RB_LSB  = 0;

  // Park select is the bitwise inverse of the pass select
  localparam logic ALU_PARK_INV = 1'b1;

  localparam logic [3:0] ALU_S_ADD  = 4'b1001;
  localparam logic [3:0] ALU_S_SUB  = 4'b0110;
  localparam logic [3:0] ALU_S_XOR  = 4'b0110;  // with M=1
  localparam logic [3:0] ALU_S_ZERO = 4'b0011;

  function automatic logic [3:0] park_sel(input logic [3:0] s);
    return ALU_PARK_INV ? ~s : s;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x4-bit register file: one read pair, CAP write port has priority over external load.
module alu_seq_regfile #(
  parameter int unsigned NREG = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_ra_idx,
  input  logic [1:0] i_rb_idx,
  output logic [3:0] o_ra_data,
  output logic [3:0] o_rb_data,
  input  logic       i_cap_we,
  input  logic [1:0] i_cap_addr,
  input  logic [3:0] i_cap_data,
  input  logic       i_ext_we,
  input  logic [1:0] i_ext_addr,
  input  logic [3:0] i_ext_data
);

  logic [3:0] r_regs [NREG];

  // Register storage; CAP write wins a same-address collision
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (i_cap_we && (i_cap_addr == 2'(i))) begin
          r_regs[i] <= i_cap_data;
        end else if (i_ext_we && (i_ext_addr == 2'(i))) begin
          r_regs[i] <= i_ext_data;
        end
      end
    end
  end

  // Asynchronous read pair
  always_comb begin
    o_ra_data = r_regs[i_ra_idx];
    o_rb_data = r_regs[i_rb_idx];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one instruction at a time through an external 4-bit ALU, with 8-bit chained ops.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NREG          = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [12:0]  in_instr,
  input  logic         wr_en,
  input  logic [1:0]   wr_addr,
  input  logic [3:0]   wr_data,
  output logic         res_valid,
  output logic [7:0]   res_data,
  output logic         flag_c,
  output logic         flag_z,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_cn,
  input  logic [3:0]   alu_f,
  input  logic         alu_co
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e           r_state, w_state_next;
  logic             r_wide, r_hi, r_ra_hi, r_rb_hi;
  logic [1:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_a, r_b, r_s, r_f_lo;
  logic             r_m, r_cn;
  logic [7:0]       r_res;
  logic             r_flag_c, r_flag_z;

  logic             w_accept, w_low_done, w_last_cap, w_cap_we, w_cn_first;
  logic [1:0]       w_ra_idx, w_rb_idx, w_cap_addr;
  logic [3:0]       w_ra_data, w_rb_data;
  logic [7:0]       w_final;

  assign w_accept   = in_valid && (r_state == StIdle);
  assign w_low_done = (r_state == StCap) && r_wide && !r_hi;
  assign w_last_cap = (r_state == StCap) && !w_low_done;
  assign w_cap_we   = (r_state == StCap);
  assign w_cap_addr = r_wide ? {r_rd[1], r_hi} : r_rd;
  // M=1 forces no carry-in; otherwise carry-in only when CI asks for the flag
  assign w_cn_first = in_instr[I_M] | ~(in_instr[I_CI] & r_flag_c);
  assign w_final    = r_wide ? {alu_f, r_f_lo} : {4'h0, alu_f};

  // Operand read indices: new instruction while idle, odd (high) pair otherwise
  always_comb begin
    w_ra_idx = in_instr[RA_MSB:RA_LSB];
    w_rb_idx = in_instr[RB_MSB:RB_LSB];
    if (r_state == StIdle) begin
      if (in_instr[I_WIDE]) begin
        w_ra_idx[0] = 1'b0;
        w_rb_idx[0] = 1'b0;
      end
    end else begin
      w_ra_idx = {r_ra_hi, 1'b1};
      w_rb_idx = {r_rb_hi, 1'b1};
    end
  end

  alu_seq_regfile #(
    .NREG(NREG)
  ) u_regfile (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ra_idx  (w_ra_idx),
    .i_rb_idx  (w_rb_idx),
    .o_ra_data (w_ra_data),
    .o_rb_data (w_rb_data),
    .i_cap_we  (w_cap_we),
    .i_cap_addr(w_cap_addr),
    .i_cap_data(alu_f),
    .i_ext_we  (wr_en),
    .i_ext_addr(wr_addr),
    .i_ext_data(wr_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StPark;
      StPark:  w_state_next = StDrive;
      StDrive: if (r_cnt == '0) w_state_next = StCap;
      StCap:   w_state_next = w_low_done ? StPark : StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: handshake, retire pulse, ALU select (inverted while parking)
  always_comb begin
    in_ready  = (r_state == StIdle);
    res_valid = (r_state == StDone);
    alu_s     = (r_state == StPark) ? park_sel(r_s) : r_s;
  end

  // Pass operands, mode and carry-in, latched on entry to each PARK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wide  <= 1'b0;
      r_hi    <= 1'b0;
      r_rd    <= '0;
      r_ra_hi <= 1'b0;
      r_rb_hi <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_m     <= 1'b1;
      r_cn    <= 1'b1;
      r_f_lo  <= '0;
    end else if (w_accept) begin
      r_wide  <= in_instr[I_WIDE];
      r_hi    <= 1'b0;
      r_rd    <= in_instr[RD_MSB:RD_LSB];
      r_ra_hi <= in_instr[RA_MSB];
      r_rb_hi <= in_instr[RB_MSB];
      r_a     <= w_ra_data;
      r_b     <= w_rb_data;
      r_s     <= in_instr[S_MSB:S_LSB];
      r_m     <= in_instr[I_M];
      r_cn    <= w_cn_first;
    end else if (w_low_done) begin
      r_hi    <= 1'b1;
      r_a     <= w_ra_data;
      r_b     <= w_rb_data;
      r_f_lo  <= alu_f;
      r_cn    <= r_m | ~alu_co;  // chain low-pass carry into the high pass
    end
  end

  // Settle counter for DRIVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == StPark) begin
      r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if ((r_state == StDrive) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Result and flags, visible from DONE onward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res    <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (w_last_cap) begin
      r_res    <= w_final;
      r_flag_z <= (w_final == 8'h00);
      if (!r_m) r_flag_c <= alu_co;
    end
  end

  assign res_data = r_res;
  assign flag_c   = r_flag_c;
  assign flag_z   = r_flag_z;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_m    = r_m;
  assign alu_cn   = r_cn;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing controller that drives the team's 4-bit combinational ALU (A, B, S, M, CN in; F, CO out) from the issuing side.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4x4-bit register file.
- Drives ALU inputs, captures F/CO, writes back, and keeps carry and zero flags.
- Supports 8-bit "wide" operations as two chained nibble passes, low nibble first.

Parameters:
- SETTLE_CYCLES, default 1: number of cycles ALU inputs are held stable before F/CO are sampled (minimum 1).
- NREG, default 4: register-file depth. Fixed at 4 by 2-bit index fields.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  controller idle, can accept an instruction
- in_instr  in  13  [12] wide, [11:8] S, [7] M, [6] CI (1 = use flag_c as carry-in), [5:4] rd, [3:2] ra, [1:0] rb
- wr_en  in  1  external register load
- wr_addr  in  2  load index
- wr_data  in  4  load data
- res_valid  out  1  one-cycle pulse, instruction retired
- res_data  out  8  result; narrow ops zero-extended
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- alu_a, alu_b  out  4  ALU operands
- alu_s  out  4  ALU function select
- alu_m  out  1  ALU mode (1 = logic, 0 = arithmetic)
- alu_cn  out  1  ALU carry-in, active-low (0 = carry in)
- alu_f  in  4  ALU result
- alu_co  in  1  ALU carry-out

Behaviour:
Reset (async, rst_n=0):
- State IDLE; R0..R3 = 0; flag_c = flag_z = 0; res_valid = 0; res_data = 0.
- alu_a = alu_b = 0; alu_s = 4'b0000; alu_m = 1; alu_cn = 1.
- in_ready = 1 once rst_n is released.

Handshake:
- in_ready = (state == IDLE).
- An instruction is accepted when in_valid & in_ready are both high at a clk edge; it is latched into an internal instruction register.

ALU interface rule:
- The ALU re-evaluates only on a change of S.
- Every pass therefore starts with one PARK cycle driving alu_s = ~S. The operand and mode outputs are already at their pass values during PARK.
- Then DRIVE presents alu_s = S for SETTLE_CYCLES cycles.

States:
- IDLE -> PARK on accept.
- PARK -> DRIVE, which loads the settle counter with SETTLE_CYCLES-1.
- DRIVE: decrement the counter; at 0 go to CAP.
- CAP: sample alu_f/alu_co.
  - Narrow, or high pass of a wide op -> DONE.
  - Low pass of a wide op -> PARK (high pass).
- DONE: res_valid = 1 for one cycle; update res_data and flags; -> IDLE.

Operands and carry-in:
- Narrow op: A = R[ra], B = R[rb], write R[rd].
- Wide op: index bit 0 is ignored; pair n = {R[n|1], R[n&2]}.
  - Low pass uses the even registers; high pass uses the odd registers.
- First-pass carry-in: cin = CI & flag_c; alu_cn = ~cin.
- High-pass carry-in: alu_cn = ~co_lo, where co_lo is alu_co captured at the low-pass CAP.
- When M=1, alu_cn is driven to 1 and CO is ignored.

Write-back and flags:
- The register file is written at each CAP (the low nibble at the low-pass CAP).
- flag_z = (result == 0) over the full op width; updated on every instruction.
- flag_c = final-pass alu_co; updated only when M=0, otherwise held.

External load:
- wr_en writes R[wr_addr] in any state.
- Same-cycle collision with a CAP write to the same register: CAP wins.
- A write to a source register while the controller is busy does not affect the in-flight instruction, because operands are latched at PARK.

Latency:
- Narrow op: accept at edge T, res_valid high in cycle T+3+SETTLE_CYCLES.
- Wide op: 2+SETTLE_CYCLES additional cycles.

Other rules:
- in_valid deasserted while busy: no effect.
- Reset mid-operation: abort immediately, with no write-back of any uncompleted pass.

Decomposition:
- Shared package alu_seq_pkg holds:
  - the state enum;
  - instruction field position constants;
  - ALU_PARK_INV, meaning the park select is the bitwise inverse of S;
  - S codes ALU_S_ADD = 4'b1001, ALU_S_SUB = 4'b0110, ALU_S_XOR = 4'b0110 (with M=1), ALU_S_ZERO = 4'b0011.
- One sub-module, alu_seq_regfile: 4x4 registers, one read-pair port, two write ports (CAP and external) with the fixed priority above.

Test Plan:
1. Load R0=5, R1=3; narrow instr S=1001, M=0, CI=0, rd=2, ra=0, rb=1 -> alu_cn=1, R2=8, res_data=8'h08, flag_c=0, flag_z=0; res_valid in cycle T+4 (SETTLE_CYCLES=1).
2. Wide ADD: R1:R0=8'h1F, R3:R2=8'h01, rd=0, ra=0, rb=2 -> low pass CO=1, high pass alu_cn=0, R1:R0=8'h20, flag_c=0, res_valid at T+7.
3. Set flag_c=1 via a carry-producing add, then S=1001, M=1 (XNOR) with R0=5, R1=3 -> result 4'h9, flag_c stays 1, alu_cn=1 throughout.
4. S=0011, M=1 -> result 0, flag_z=1; alu_s observed 4'b1100 during PARK, 4'b0011 during DRIVE.
5. Hold in_valid high continuously -> in_ready low from PARK through DONE; the second instruction is accepted on the cycle after res_valid; wr_en to rd at that instruction's CAP leaves the CAP value in rd.
6. Drop rst_n during DRIVE of a wide op -> all outputs return to reset values asynchronously; registers are 0; no res_valid pulse.
